kbd_fifo_ctrl: RTL
==================

KBD_FIFO_CTRL -- requirements
Module: kbd_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; legal values 2, 4, 8.
REQ-002 Hclock  in  1  sole clock; all state updates on rising edge.
REQ-003 Hreset  in  1  synchronous, active-high reset.
REQ-004 char_valid  in  1  one-cycle strobe from the keyboard decoder: a character is presented.
REQ-005 char_data  in  8  ASCII character, qualified by char_valid.
REQ-006 bus_req  in  1  CPU access request, held high until bus_ack is seen.
REQ-007 bus_we  in  1  1 = write, 0 = read; sampled with bus_req.
REQ-008 bus_addr  in  1  0 = DATA register, 1 = STATUS/CTRL register.
REQ-009 bus_wdata  in  8  write data.
REQ-010 bus_rdata  out  8  read data, valid while bus_ack = 1.
REQ-011 bus_ack  out  1  one-cycle transaction acknowledge.
REQ-012 irq  out  1  level interrupt request to the CPU.

Function
REQ-013 The FIFO SHALL be circular, DEPTH x 8, with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of 0..DEPTH.
REQ-014 char_valid with count < DEPTH SHALL write char_data and increment count on the same edge.
REQ-015 char_valid with count = DEPTH and no pop that cycle SHALL drop the character and set the sticky overflow flag.
REQ-016 Simultaneous push and pop SHALL both take effect; count is unchanged; overflow is not set, even when full.
REQ-017 The bus FSM SHALL have states IDLE, RESP, WAIT. IDLE->RESP when bus_req = 1, capturing bus_we, bus_addr and bus_wdata and performing the access. RESP->WAIT unconditionally, with bus_ack = 1 for exactly that cycle. WAIT->IDLE when bus_req = 0.
REQ-018 Latency SHALL be fixed: bus_ack is asserted 1 cycle after bus_req is first sampled high; exactly one access per request.
REQ-019 A DATA read with count > 0 SHALL return the head entry and pop it (one pop per transaction).
REQ-020 A DATA read with count = 0 SHALL return 0x00 with no pointer change.
REQ-021 DATA writes SHALL be acknowledged and ignored.
REQ-022 A STATUS read SHALL return:
  - bit0 = not_empty
  - bit1 = full
  - bit2 = overflow
  - bit3 = irq_en
  - bits7:4 = count
  Values are sampled at the IDLE->RESP edge.
REQ-023 CTRL write fields:
  - bit2 = 1: clears overflow.
  - bit3: loads irq_en.
  - bit4 = 1: flushes the FIFO (pointers and count to 0).
  - Other bits are ignored.
REQ-024 Overflow set and overflow clear on the same edge: set SHALL win.
REQ-025 Flush on the same edge as char_valid: flush SHALL win and the character is discarded without setting overflow.
REQ-026 bus_rdata SHALL be 0x00 whenever bus_ack = 0.
REQ-027 irq SHALL be registered, equal to irq_en & (not_empty | overflow), updated one cycle after the causing event.

Reset
REQ-028 When Hreset = 1 at a clock edge:
  - pointers, count, overflow and irq_en SHALL become 0;
  - FSM SHALL go to IDLE;
  - bus_ack = 0, bus_rdata = 0x00, irq = 0.
REQ-029 Reset SHALL override any in-flight transaction or push; FIFO contents need not be cleared.

Configuration
REQ-030 Macro KBD_FIFO_IRQ_EN defined: irq_en bit and irq generation SHALL be present as specified.
REQ-031 Macro KBD_FIFO_IRQ_EN undefined:
  - irq SHALL be constant 0;
  - STATUS bit3 SHALL read 0;
  - CTRL bit3 SHALL be ignored;
  - all other behaviour is unchanged.

Verification
REQ-032 Push 0x41, 0x42, 0x43, then three DATA reads -> rdata 0x41, 0x42, 0x43; each ack exactly 1 cycle after req; fourth read -> 0x00.
REQ-033 DEPTH = 8: push 9 characters with no reads -> STATUS = 0x86 (count 8, full, overflow); the first 8 characters are read back in order.
REQ-034 When full, char_valid coincident with a pop edge -> count stays 8, overflow stays 0, new character appears last.
REQ-035 CTRL write 0x08, then one push -> irq = 1 one cycle after the push; DATA read drains the FIFO -> irq = 0 one cycle after the pop; without the macro, irq stays 0 throughout.
REQ-036 Overflow set, then CTRL write 0x14 -> STATUS reads 0x00 (flushed, overflow cleared).
REQ-037 Assert Hreset while the FSM is in RESP with count 5 -> next cycle bus_ack = 0, STATUS read returns 0x00; bus_req held high through reset starts one new transaction.

Source files
------------

// File: rtl/kbd_fifo_ctrl.sv
// Keyboard character FIFO with a two-register CPU bus port (DATA / STATUS-CTRL).
// Define KBD_FIFO_IRQ_EN to build in the interrupt enable bit and the irq output.
module kbd_fifo_ctrl #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       Hclock,
    input  logic       Hreset,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    input  logic       bus_req,
    input  logic       bus_we,
    input  logic       bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_ack,
    output logic       irq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESP,
        S_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ack_q, ack_d;
    logic [7:0]       rdata_q, rdata_d;

    logic access_c, rd_data_c, rd_stat_c, wr_ctrl_c;
    logic not_empty_c, full_c, pop_c, push_c, flush_c;
    logic irq_en_c;
    logic unused_c;

    // Bus access decode; the access itself happens on the IDLE->RESP edge.
    always_comb begin
        access_c    = (state_q == S_IDLE) && bus_req;
        rd_data_c   = access_c && !bus_we && !bus_addr;
        rd_stat_c   = access_c && !bus_we && bus_addr;
        wr_ctrl_c   = access_c && bus_we && bus_addr;
        not_empty_c = (cnt_q != '0);
        full_c      = (cnt_q == CNT_W'(DEPTH));
        pop_c       = rd_data_c && not_empty_c;
        flush_c     = wr_ctrl_c && bus_wdata[4];
        push_c      = char_valid && !flush_c && (!full_c || pop_c);
    end

    // Next-state: bus FSM, FIFO pointers/count, overflow flag and response data.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ack_d   = access_c;
        rdata_d = 8'h00;

        unique case (state_q)
            S_IDLE:  if (bus_req) state_d = S_RESP;
            S_RESP:  state_d = S_WAIT;
            S_WAIT:  if (!bus_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (pop_c) begin
            rdata_d = mem_q[rptr_q];
        end
        if (rd_stat_c) begin
            rdata_d = {4'(cnt_q), irq_en_c, ovf_q, full_c, not_empty_c};
        end

        if (flush_c) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_c) wptr_d = wptr_q + PTR_W'(1);
            if (pop_c)  rptr_d = rptr_q + PTR_W'(1);
            if (push_c && !pop_c) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        // A dropped character outranks a same-edge clear request.
        if (wr_ctrl_c && bus_wdata[2]) ovf_d = 1'b0;
        if (char_valid && full_c && !pop_c && !flush_c) ovf_d = 1'b1;
    end

    always_ff @(posedge Hclock) begin
        if (Hreset) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge Hclock) begin
        if (push_c) begin
            mem_q[wptr_q] <= char_data;
        end
    end

    assign bus_ack   = ack_q;
    assign bus_rdata = rdata_q;

`ifdef KBD_FIFO_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    // irq follows the registered FIFO state, so it lags the causing edge by one cycle.
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl_c) irq_en_d = bus_wdata[3];
        irq_d = irq_en_q && (not_empty_c || ovf_q);
    end

    always_ff @(posedge Hclock) begin
        if (Hreset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_c = irq_en_q;
    assign irq      = irq_q;
    assign unused_c = ^{bus_wdata[7:5], bus_wdata[1:0]};
`else
    assign irq_en_c = 1'b0;
    assign irq      = 1'b0;
    assign unused_c = ^{bus_wdata[7:5], bus_wdata[3], bus_wdata[1:0]};
`endif

endmodule
